spiker_result_writer: RTL and testbench
=======================================

# spiker_result_writer

Parametrised successor to the single-shot spike result sampler. It captures the spiking core's output vector over one inference, either as a last-sample snapshot or as a sticky OR across all time steps. The finished result is published into a double-buffered result bank with a valid/ack handshake, an overflow flag and a time-step count. It sits between the spiking core output bus and the adapter register file; a thin wrapper maps `result_o`, `result_valid_o`, `overflow_o` and `steps_o` into the hw2reg struct.

## Interface
- `WIDTH`, default 32: register word width in bits.
- `N_REG`, default 24: number of result words.
- `DATA_WIDTH`, default `N_REG*WIDTH`: spike vector width. Must equal `N_REG*WIDTH`; elaboration error otherwise.
- `STEP_W`, default 16: width of the time-step counter.
- One clock; reset is asynchronous and active-low.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `test_mode_i`, in, 1: when high, every accepted sample is treated as last.
- `data_i`, in, `DATA_WIDTH`: spike vector for one time step. Bit `i*WIDTH+j` maps to word `i`, bit `j`.
- `valid_i`, in, 1: `data_i` is valid this cycle. One sample per asserted cycle; there is no backpressure.
- `last_i`, in, 1: qualifies `valid_i`; marks the final time step of the inference.
- `mode_i`, in, 1: 0 = SNAPSHOT, 1 = OR_ACC. Latched on the first sample of each inference.
- `clear_i`, in, 1: software clear pulse.
- `ack_i`, in, 1: software has read the result bank.
- `result_o`, out, `DATA_WIDTH`: published result bank. Word `i` is `[(i+1)*WIDTH-1 -: WIDTH]`.
- `result_valid_o`, out, 1: result bank holds an unacknowledged result.
- `overflow_o`, out, 1: sticky; an inference completed while the previous result was still unacknowledged.
- `steps_o`, out, `STEP_W`: number of samples in the published inference. Saturates at all-ones.
- `busy_o`, out, 1: an inference is in progress (state ACC).

## Operation
- FSM states:
  - IDLE: accumulator empty.
  - ACC: at least one sample taken, last not yet seen.
- IDLE + `valid_i`:
  - `acc` = `data_i`, `steps` = 1, mode latched.
  - If `last_i` or `test_mode_i`: publish, stay IDLE. Otherwise go to ACC.
- ACC + `valid_i`:
  - `acc` = `data_i` (SNAPSHOT) or `acc | data_i` (OR_ACC).
  - `steps` = `steps`+1, saturating.
  - If `last_i` or `test_mode_i`: publish the updated value and go to IDLE.
- Publish:
  - If `result_valid_o`=0: `result_o` takes the final accumulator value, `steps_o` takes the final count, `result_valid_o` is set.
  - If `result_valid_o`=1 and no `ack_i` this cycle: the result is dropped, the bank is unchanged and `overflow_o` is set.
  - Publish and `ack_i` in the same cycle: the new result is written, `result_valid_o` stays 1, no overflow.
  - After a publish, `acc` and `steps` are zeroed.
- `ack_i` without a publish clears `result_valid_o`. `ack_i` while `result_valid_o`=0 has no effect.
- `clear_i`:
  - Go to IDLE; zero `acc`, `steps`, `result_o`, `steps_o`, `result_valid_o` and `overflow_o`.
  - Takes priority over `valid_i` and `ack_i` in the same cycle; that sample is dropped.
- A `mode_i` change during ACC is ignored until the next inference.
- Reset mid-inference behaves as `clear_i`: all outputs 0, state IDLE.

## Timing
- Reset values: `result_o`=0, `result_valid_o`=0, `overflow_o`=0, `steps_o`=0, `busy_o`=0.
- Publish latency: `result_o`, `steps_o` and `result_valid_o` update on the clock edge that samples `valid_i`&`last_i`, so they are visible in the following cycle.
- `busy_o` is registered: it rises the cycle after the first non-last sample and falls the cycle after the last sample.
- `ack_i` takes effect on the next edge.
- Back-to-back inferences, with last followed immediately by the next first sample, are supported at full rate with no idle cycle.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Structure
- Package `spiker_writer_pkg` holds:
  - `typedef enum logic {MODE_SNAPSHOT, MODE_OR_ACC} wr_mode_e`
  - `typedef enum logic {ST_IDLE, ST_ACC} wr_state_e`
- Sub-module `spiker_word_acc`, one instance per word (`N_REG` instances via generate). It holds one `WIDTH`-bit accumulator lane with load, OR, and zero controls.
- The top level holds the FSM, step counter, result bank and handshake flags.

## Test plan
- SNAPSHOT, 3 samples `0x1`, `0x2`, `0x4` in word 0, last on the third → word 0 = `0x4`, `steps_o`=3, `result_valid_o`=1 one cycle later.
- OR_ACC, same stimulus → word 0 = `0x7`. Word 23 bit 31 set in sample 2 only → word 23 = `0x80000000`.
- Two inferences with no ack in between → first result retained, `overflow_o`=1. Then `ack_i` → `result_valid_o`=0 and `overflow_o` stays 1 until `clear_i`.
- Publish coincident with `ack_i` → new result visible, `result_valid_o`=1, `overflow_o`=0.
- `clear_i` coincident with `valid_i` in ACC → all outputs 0, state IDLE, sample dropped. Also: `rst_ni` asserted mid-inference → same result.
- `test_mode_i`=1, 5 samples without `last_i` → 5 publishes, each with `steps_o`=1. `STEP_W`=2 with 6 samples → `steps_o`=3 (saturated).

Source files
------------

// File: rtl/spiker_writer_pkg.sv
// Shared types for the spike result writer: accumulation mode and FSM state.
package spiker_writer_pkg;

    typedef enum logic {MODE_SNAPSHOT, MODE_OR_ACC} wr_mode_e;
    typedef enum logic {ST_IDLE, ST_ACC} wr_state_e;

endpackage

// File: rtl/spiker_word_acc.sv
// One WIDTH-bit accumulator lane: snapshot load, sticky OR, and zeroing.
module spiker_word_acc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             or_i,
    input  logic             zero_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] acc_q;

    // Value the lane holds after this sample; also the value a publish captures.
    always_comb begin
        next_o = or_i ? (acc_q | data_i) : data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (zero_i) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= next_o;
        end
    end

endmodule

// File: rtl/spiker_result_writer.sv
// Captures the spiking core output over one inference and publishes it into a
// result bank with valid/ack handshake, sticky overflow and a saturating step count.
module spiker_result_writer
    import spiker_writer_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned N_REG      = 24,
    parameter int unsigned DATA_WIDTH = N_REG * WIDTH,
    parameter int unsigned STEP_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    input  logic                  mode_i,
    input  logic                  clear_i,
    input  logic                  ack_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  result_valid_o,
    output logic                  overflow_o,
    output logic [STEP_W-1:0]     steps_o,
    output logic                  busy_o
);

    if (DATA_WIDTH != N_REG * WIDTH) begin : g_bad_width
        $error("spiker_result_writer: DATA_WIDTH must equal N_REG*WIDTH");
    end

    wr_state_e             state_q;
    wr_mode_e              mode_q;
    logic [STEP_W-1:0]     steps_q;
    logic [STEP_W-1:0]     steps_inc;
    logic [STEP_W-1:0]     steps_next;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] result_q;
    logic [STEP_W-1:0]     steps_out_q;
    logic                  result_valid_q;
    logic                  overflow_q;
    logic                  publish;
    logic                  or_en;
    logic                  acc_zero;

    always_comb begin
        publish    = valid_i && (last_i || test_mode_i) && !clear_i;
        // The first sample of an inference always loads, whatever the mode.
        or_en      = (state_q == ST_ACC) && (mode_q == MODE_OR_ACC);
        acc_zero   = clear_i || publish;
        steps_inc  = (steps_q == {STEP_W{1'b1}}) ? steps_q : steps_q + 1'b1;
        steps_next = (state_q == ST_IDLE) ? STEP_W'(1) : steps_inc;
    end

    for (genvar w = 0; w < N_REG; w++) begin : g_word
        spiker_word_acc #(
            .WIDTH (WIDTH)
        ) u_word_acc (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .load_i (valid_i),
            .or_i   (or_en),
            .zero_i (acc_zero),
            .data_i (data_i[w*WIDTH +: WIDTH]),
            .next_o (acc_next[w*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_SNAPSHOT;
            steps_q        <= '0;
            result_q       <= '0;
            steps_out_q    <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (clear_i) begin
            state_q        <= ST_IDLE;
            steps_q        <= '0;
            result_q       <= '0;
            steps_out_q    <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            if (valid_i) begin
                if (state_q == ST_IDLE) begin
                    mode_q <= wr_mode_e'(mode_i);
                end
                if (publish) begin
                    state_q <= ST_IDLE;
                    steps_q <= '0;
                end else begin
                    state_q <= ST_ACC;
                    steps_q <= steps_next;
                end
            end
            if (publish) begin
                // An ack in the same cycle frees the bank for the new result.
                if (!result_valid_q || ack_i) begin
                    result_q       <= acc_next;
                    steps_out_q    <= steps_next;
                    result_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (ack_i) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        result_o       = result_q;
        result_valid_o = result_valid_q;
        overflow_o     = overflow_q;
        steps_o        = steps_out_q;
        busy_o         = (state_q == ST_ACC);
    end

endmodule

// File: tb/tb_spiker_result_writer.sv
// Directed bench: default-size writer plus a small STEP_W=2 instance for saturation.
module tb_spiker_result_writer;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic         tm, vld, lst, md, clr, ack;
    logic [767:0] dat;
    logic [767:0] res;
    logic         rv, ov, bsy;
    logic [15:0]  stp;

    spiker_result_writer u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .test_mode_i    (tm),
        .data_i         (dat),
        .valid_i        (vld),
        .last_i         (lst),
        .mode_i         (md),
        .clear_i        (clr),
        .ack_i          (ack),
        .result_o       (res),
        .result_valid_o (rv),
        .overflow_o     (ov),
        .steps_o        (stp),
        .busy_o         (bsy)
    );

    // Small instance for step saturation
    logic        s_vld, s_lst;
    logic [15:0] s_dat, s_res;
    logic        s_rv, s_ov, s_bsy;
    logic [1:0]  s_stp;

    spiker_result_writer #(
        .WIDTH  (8),
        .N_REG  (2),
        .STEP_W (2)
    ) u_dut_sat (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .test_mode_i    (1'b0),
        .data_i         (s_dat),
        .valid_i        (s_vld),
        .last_i         (s_lst),
        .mode_i         (1'b1),
        .clear_i        (1'b0),
        .ack_i          (1'b0),
        .result_o       (s_res),
        .result_valid_o (s_rv),
        .overflow_o     (s_ov),
        .steps_o        (s_stp),
        .busy_o         (s_bsy)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;
    logic [767:0] exp_res;
    logic [767:0] or_res;

    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [767:0] r, input int s,
                           input logic v, input logic o, input logic b);
        chk({tag, ".result"}, res, r);
        chk({tag, ".steps"}, 768'(stp), 768'(s));
        chk({tag, ".valid"}, 768'(rv), 768'(v));
        chk({tag, ".overflow"}, 768'(ov), 768'(o));
        chk({tag, ".busy"}, 768'(bsy), 768'(b));
    endtask

    initial begin
        tm = 0; vld = 0; lst = 0; md = 0; clr = 0; ack = 0; dat = '0;
        s_vld = 0; s_lst = 0; s_dat = '0;
        #2 rst_ni = 1'b0;
        #2;
        chk_all("reset", '0, 0, 0, 0, 0);
        step();
        rst_ni = 1'b1;
        step();

        // SNAPSHOT: 1, 2, 4 -> 4
        md = 0; vld = 1; dat = 768'h1; step();
        chk("snap.busy1", 768'(bsy), 768'(1));
        dat = 768'h2; step();
        chk("snap.valid_pre", 768'(rv), 768'(0));
        dat = 768'h4; lst = 1; step();
        vld = 0; lst = 0;
        chk_all("snap", 768'h4, 3, 1, 0, 0);
        ack = 1; step(); ack = 0;
        chk("snap.ack", 768'(rv), 768'(0));

        // OR_ACC with a mode_i change mid-inference that must be ignored
        or_res = '0; or_res[767] = 1'b1;
        md = 1; vld = 1; dat = 768'h1; step();
        md = 0; dat = or_res | 768'h2; step();
        dat = 768'h4; lst = 1; step();
        vld = 0; lst = 0;
        exp_res = or_res | 768'h7;
        chk_all("oracc", exp_res, 3, 1, 0, 0);

        // Second inference without ack -> dropped, overflow
        vld = 1; lst = 1; dat = 768'h55; step();
        vld = 0; lst = 0;
        chk_all("ovf", exp_res, 3, 1, 1, 0);
        ack = 1; step(); ack = 0;
        chk_all("ovf.ack", exp_res, 3, 0, 1, 0);
        step();
        chk("ovf.sticky", 768'(ov), 768'(1));

        // Clear wipes everything
        clr = 1; step(); clr = 0;
        chk_all("clear", '0, 0, 0, 0, 0);

        // Publish coincident with ack
        vld = 1; lst = 1; dat = 768'hAA; step();
        vld = 0; lst = 0;
        chk_all("pub1", 768'hAA, 1, 1, 0, 0);
        md = 1; vld = 1; dat = 768'h0B; step();
        dat = 768'hB0; lst = 1; ack = 1; step();
        vld = 0; lst = 0; ack = 0;
        chk_all("pubak", 768'hBB, 2, 1, 0, 0);

        // Clear coincident with a sample in ACC
        md = 0; vld = 1; dat = 768'h3; step();
        chk("clracc.busy", 768'(bsy), 768'(1));
        dat = 768'hF0; lst = 1; clr = 1; ack = 1; step();
        vld = 0; lst = 0; clr = 0; ack = 0;
        chk_all("clracc", '0, 0, 0, 0, 0);
        vld = 1; lst = 1; dat = 768'h9; step();
        vld = 0; lst = 0;
        chk_all("postclr", 768'h9, 1, 1, 0, 0);

        // Reset mid-inference
        vld = 1; dat = 768'h5; step();
        chk("rst.busy", 768'(bsy), 768'(1));
        rst_ni = 1'b0; vld = 0;
        #1;
        chk_all("midrst", '0, 0, 0, 0, 0);
        #1 rst_ni = 1'b1;
        vld = 1; lst = 1; dat = 768'h6; step();
        vld = 0; lst = 0;
        chk_all("postrst", 768'h6, 1, 1, 0, 0);
        ack = 1; step(); ack = 0;

        // test_mode: every sample publishes with steps 1
        tm = 1;
        for (int i = 0; i < 5; i++) begin
            vld = 1; dat = 768'(i + 1); ack = (i > 0);
            step();
            chk_all("tmode", 768'(i + 1), 1, 1, 0, 0);
        end
        vld = 0; ack = 0; tm = 0;

        // STEP_W=2 saturation: six OR samples
        for (int k = 0; k < 6; k++) begin
            s_vld = 1; s_lst = (k == 5); s_dat = 16'(1 << k);
            step();
        end
        s_vld = 0; s_lst = 0;
        chk("sat.steps", 768'(s_stp), 768'(3));
        chk("sat.result", 768'(s_res), 768'h3F);
        chk("sat.valid", 768'(s_rv), 768'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
